// File: rtl/imm_decode_pipe.sv
// Immediate decode stage: classifies the instruction format, builds the XLEN immediate and
// PC-relative target, and buffers the result in a two-slot (output + skid) valid/ready pipe.
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_target,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  fmt_e        w_fmt;
  logic [31:0] w_imm32;
  entry_t      w_entry;
  logic        w_accept;
  logic        w_out_free;

  entry_t           r_out;
  entry_t           r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_fmt = FMT_ILL;
    unique case (in_instr[6:0])
      7'b0110111, 7'b0010111:                      w_fmt = FMT_U;
      7'b1101111:                                  w_fmt = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: w_fmt = FMT_I;
      7'b0100011:                                  w_fmt = FMT_S;
      7'b1100011:                                  w_fmt = FMT_B;
      7'b1110011:                                  w_fmt = in_instr[14] ? FMT_Z : FMT_I;
      7'b0110011, 7'b0111011:                      w_fmt = FMT_R;
      default:                                     w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_imm32 = 32'd0;
    unique case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_instr[31:12], 12'd0};
      FMT_J:   w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z:   w_imm32 = {27'd0, in_instr[19:15]};
      default: w_imm32 = 32'd0;
    endcase
  end

  // Bit 31 of the 32-bit form is the sign for every format (Z keeps it 0), so one cast widens all.
  always_comb begin
    w_entry        = '0;
    w_entry.imm    = XLEN'($signed(w_imm32));
    w_entry.fmt    = w_fmt;
    w_entry.pc     = in_pc;
    w_entry.target = in_pc + w_entry.imm;
  end

  assign in_ready   = !r_skid_valid;
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_out_free = !r_out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A full skid implies in_ready was low, so no acceptance competes with the skid move.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        if (w_accept) r_out <= w_entry;
        r_out_valid <= w_accept;
      end
    end else if (w_accept) begin
      r_skid       <= w_entry;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && (w_fmt == FMT_ILL) && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_pc      = r_out.pc;
  assign out_target  = r_out.target;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench: one XLEN=32/CNT_W=16 instance and one XLEN=64/CNT_W=2 instance share stimulus;
// each step checks the relevant instance against hand-computed values.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        rdy32, val32, rdy64, val64;
  logic [31:0] imm32, pc32, tgt32;
  logic [63:0] imm64, pc64, tgt64;
  logic [2:0]  fmt32, fmt64;
  logic [15:0] cnt32;
  logic [1:0]  cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(val32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_pc(pc32), .out_target(tgt32), .illegal_cnt(cnt32)
  );

  imm_decode_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(val64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_pc(pc64), .out_target(tgt64), .illegal_cnt(cnt64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    #12;
    check("rst_valid32", {63'd0, val32}, 64'd0);
    check("rst_ready32", {63'd0, rdy32}, 64'd1);
    check("rst_cnt32",   {48'd0, cnt32}, 64'd0);
    check("rst_imm64",   imm64, 64'd0);
    check("rst_fmt64",   {61'd0, fmt64}, 64'd0);
    check("rst_pc64",    pc64, 64'd0);
    check("rst_tgt64",   tgt64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode with out_ready=1: output slot reloads each cycle.
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 64'h0);
    tick();
    check("addi_valid", {63'd0, val32}, 64'd1);
    check("addi_fmt",   {61'd0, fmt32}, 64'd1);
    check("addi_imm",   {32'd0, imm32}, 64'hFFFFFFFF);
    check("addi_tgt",   {32'd0, tgt32}, 64'hFFFFFFFF);
    drive(1'b1, 32'hFE112E23, 64'h0);
    tick();
    check("sw_valid", {63'd0, val32}, 64'd1);
    check("sw_fmt",   {61'd0, fmt32}, 64'd2);
    check("sw_imm",   {32'd0, imm32}, 64'hFFFFFFFC);
    drive(1'b1, 32'hFE000CE3, 64'h100);
    tick();
    check("b_fmt", {61'd0, fmt32}, 64'd3);
    check("b_imm", {32'd0, imm32}, 64'hFFFFFFF8);
    check("b_tgt", {32'd0, tgt32}, 64'h000000F8);
    check("b_pc",  {32'd0, pc32},  64'h100);
    drive(1'b1, 32'h0010006F, 64'h100);
    tick();
    check("j_fmt", {61'd0, fmt32}, 64'd5);
    check("j_imm", {32'd0, imm32}, 64'h800);
    check("j_tgt", {32'd0, tgt32}, 64'h900);
    drive(1'b1, 32'h800000B7, 64'h0);
    tick();
    check("lui_fmt64", {61'd0, fmt64}, 64'd4);
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    check("lui_imm32", {32'd0, imm32}, 64'h80000000);
    drive(1'b1, 32'h3002D073, 64'h0);
    tick();
    check("csr_fmt64", {61'd0, fmt64}, 64'd6);
    check("csr_imm64", imm64, 64'h5);
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("idle_valid", {63'd0, val32}, 64'd0);

    // Backpressure: A_k = addi x1,x0,k+1 at pc 0x1000+4k.
    out_ready = 1'b0;
    check("bp_ready0", {63'd0, rdy32}, 64'd1);
    drive(1'b1, 32'h00100093, 64'h1000);
    tick();
    check("bp_a0_out", {32'd0, imm32}, 64'd1);
    check("bp_ready1", {63'd0, rdy32}, 64'd1);
    drive(1'b1, 32'h00200093, 64'h1004);
    tick();
    check("bp_ready2", {63'd0, rdy32}, 64'd0);
    check("bp_a0_hold", {32'd0, imm32}, 64'd1);
    drive(1'b1, 32'h00300093, 64'h1008);
    tick();
    check("bp_stable_imm", {32'd0, imm32}, 64'd1);
    check("bp_stable_pc",  {32'd0, pc32}, 64'h1000);
    check("bp_ready3", {63'd0, rdy32}, 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_a1_out", {32'd0, imm32}, 64'd2);
    check("bp_a1_pc",  {32'd0, pc32}, 64'h1004);
    check("bp_ready4", {63'd0, rdy32}, 64'd1);
    tick();
    check("bp_a2_out", {32'd0, imm32}, 64'd3);
    drive(1'b1, 32'h00400093, 64'h100C);
    tick();
    check("bp_a3_out", {32'd0, imm32}, 64'd4);
    check("bp_a3_tgt", {32'd0, tgt32}, 64'h1010);
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("bp_drained", {63'd0, val32}, 64'd0);

    // Flush with both slots full and an illegal instruction offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 64'h2000);
    tick();
    drive(1'b1, 32'h00200093, 64'h2004);
    tick();
    check("fl_full_ready", {63'd0, rdy32}, 64'd0);
    drive(1'b1, 32'h0000007F, 64'h2008);
    flush = 1'b1;
    tick();
    check("fl_valid", {63'd0, val32}, 64'd0);
    check("fl_ready", {63'd0, rdy32}, 64'd1);
    check("fl_cnt",   {48'd0, cnt32}, 64'd0);
    tick();
    check("fl_accept_dropped", {63'd0, val32}, 64'd0);
    check("fl_cnt_dropped",    {62'd0, cnt64}, 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    tick();
    check("fl_after_valid", {63'd0, val32}, 64'd0);
    check("fl_skid_gone", {63'd0, rdy32}, 64'd1);

    // Saturating counter on the CNT_W=2 instance.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 64'h3000);
    tick();
    check("ill_cnt1", {62'd0, cnt64}, 64'd1);
    check("ill_fmt",  {61'd0, fmt64}, 64'd7);
    check("ill_imm",  imm64, 64'd0);
    tick();
    check("ill_cnt2", {62'd0, cnt64}, 64'd2);
    tick();
    check("ill_cnt3", {62'd0, cnt64}, 64'd3);
    tick();
    check("ill_cnt_sat4", {62'd0, cnt64}, 64'd3);
    tick();
    check("ill_cnt_sat5", {62'd0, cnt64}, 64'd3);
    check("ill_cnt32",    {48'd0, cnt32}, 64'd5);

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, val64}, 64'd0);
    check("arst_ready", {63'd0, rdy64}, 64'd1);
    check("arst_cnt",   {62'd0, cnt64}, 64'd0);
    check("arst_fmt",   {61'd0, fmt64}, 64'd0);
    check("arst_pc",    pc64, 64'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0);
    rst_n = 1'b1;
    tick();
    check("arst_no_emit", {63'd0, val64}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
